// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data-memory responder for the CPU data bus
//
// Accepts one load or store at a time, checks it, commits stores into the
// on-chip RAM or formats load data, and answers with a one-cycle busReady
// (plus busErr) after WAIT_STATES extra cycles.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   busAddr   byte address of the access
//   busWe     store request (wins over busRe)
//   busRe     load request
//   strb      funct3 of the access: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   busWData  store data, right-aligned
//   busRData  formatted load data, zero for stores and errors
//   busReady  one-cycle response strobe
//   busErr    error flag, valid with busReady
module data_bus_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] busAddr,
    input  logic        busWe,
    input  logic        busRe,
    input  logic [2:0]  strb,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        busReady,
    output logic        busErr
);
    localparam int          DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [32:0] RANGE_BYTES = 33'(64'd4 << ADDR_WIDTH);
    localparam int          WAIT_INIT   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_INIT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  strb_q;
    logic        we_q;
    logic [31:0] mem [0:DEPTH-1];

    logic        req, enter_resp;
    logic [31:0] acc_addr, acc_wdata, offset, rd_word, shifted, load_val;
    logic [2:0]  acc_strb;
    logic        acc_we, range_err, funct_err, align_err, acc_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [15:0] half_sel;
    logic [3:0]  wr_mask;
    logic [31:0] wr_data;

    assign req      = busWe | busRe;
    assign busReady = (state == RESP);

    // With zero wait states RESP is entered on the very edge that samples the
    // request, so the checks and the RAM access look at the live bus in IDLE
    // and at the captured copy otherwise.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_strb  = strb_q;
        acc_we    = we_q;
        if (state == IDLE) begin
            acc_addr  = busAddr;
            acc_wdata = busWData;
            acc_strb  = strb;
            acc_we    = busWe;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: if (wait_cnt == 4'd0) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // Access checks.
    always_comb begin
        offset    = acc_addr - BASE_ADDR;
        range_err = (acc_addr < BASE_ADDR) || ({1'b0, offset} >= RANGE_BYTES);
        if (acc_we)
            funct_err = !(acc_strb == 3'b000 || acc_strb == 3'b001 || acc_strb == 3'b010);
        else
            funct_err = (acc_strb == 3'b011 || acc_strb == 3'b110 || acc_strb == 3'b111);
        align_err = ((acc_strb[1:0] == 2'b01) && acc_addr[0]) ||
                    ((acc_strb == 3'b010) && (acc_addr[1:0] != 2'b00));
        acc_err   = range_err | funct_err | align_err;
        word_idx  = offset[ADDR_WIDTH+1:2];
    end

    // Load lane selection and extension.
    always_comb begin
        rd_word  = mem[word_idx];
        shifted  = rd_word >> {acc_addr[1:0], 3'b000};
        half_sel = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_strb)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    // Store lane merge: data is replicated across lanes, the mask picks them.
    always_comb begin
        case (acc_strb)
            3'b000: begin
                wr_mask = 4'b0001 << acc_addr[1:0];
                wr_data = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                wr_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                wr_mask = 4'b1111;
                wr_data = acc_wdata;
            end
        endcase
    end

    // RAM is not cleared by reset; a reset on the commit edge suppresses it.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && acc_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            strb_q   <= 3'd0;
            we_q     <= 1'b0;
            busErr   <= 1'b0;
            busRData <= 32'd0;
        end else begin
            state  <= state_next;
            busErr <= 1'b0;
            if (state == IDLE && req) begin
                addr_q   <= busAddr;
                wdata_q  <= busWData;
                strb_q   <= strb;
                we_q     <= busWe;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                busErr   <= acc_err;
                busRData <= (acc_err || acc_we) ? 32'd0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder
module tb_data_bus_responder;
    typedef struct {
        string       nm;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        rst   [2];
    logic [31:0] addr  [2];
    logic        we    [2];
    logic        re    [2];
    logic [2:0]  strb  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        err   [2];
    logic        prev_rdy [2];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_bus_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0), .BASE_ADDR(32'h1000_0000)) dut0 (
        .clk(clk), .reset(rst[0]), .busAddr(addr[0]), .busWe(we[0]), .busRe(re[0]),
        .strb(strb[0]), .busWData(wdata[0]), .busRData(rdata[0]),
        .busReady(rdy[0]), .busErr(err[0]));

    data_bus_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BASE_ADDR(32'h1000_0000)) dut3 (
        .clk(clk), .reset(rst[1]), .busAddr(addr[1]), .busWe(we[1]), .busRe(re[1]),
        .strb(strb[1]), .busWData(wdata[1]), .busRData(rdata[1]),
        .busReady(rdy[1]), .busErr(err[1]));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int s);
        exp_t e;
        bit   have = 0;
        if (rdy[s] === 1'b1) begin
            check($sformatf("dut%0d ready_width", s), 64'(prev_rdy[s]), 64'd0);
            if (s == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            if (s == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            if (!have) begin
                n_vec++;
                n_bad++;
                $display("FAIL dut%0d unexpected_ready: got busReady=1, expected none (cycle %0d)", s, cyc);
            end else begin
                check({e.nm, " latency"}, 64'(cyc), 64'(e.cyc));
                check({e.nm, " busErr"}, 64'(err[s]), 64'(e.err));
                check({e.nm, " busRData"}, 64'(rdata[s]), 64'(e.data));
            end
        end
        prev_rdy[s] = rdy[s];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Called #1 after a rising edge; returns #1 after the edge on which the
    // next request may be presented.
    task automatic issue(input int s, input string nm, input logic w, input logic r,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] x);
        int   ws = (s == 1) ? 3 : 0;
        exp_t ex;
        ex.nm = nm; ex.err = e; ex.data = x; ex.cyc = cyc + 1 + ws;
        if (s == 0) q0.push_back(ex); else q1.push_back(ex);
        we[s] = w; re[s] = r; strb[s] = f; addr[s] = a; wdata[s] = d;
        @(posedge clk); #1;
        we[s] = 1'b0; re[s] = 1'b0; addr[s] = 32'd0; wdata[s] = 32'd0; strb[s] = 3'd0;
        repeat (ws + 1) @(posedge clk);
        #1;
    endtask

    task automatic st(input int s, input string nm, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic e);
        issue(s, nm, 1'b1, 1'b0, f, a, d, e, 32'd0);
    endtask

    task automatic ld(input int s, input string nm, input logic [2:0] f, input logic [31:0] a,
                      input logic e, input logic [31:0] x);
        issue(s, nm, 1'b0, 1'b1, f, a, 32'd0, e, x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; we[i] = 1'b0; re[i] = 1'b0; strb[i] = 3'd0;
            addr[i] = 32'd0; wdata[i] = 32'd0; prev_rdy[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d reset busReady", i), 64'(rdy[i]), 64'd0);
            check($sformatf("dut%0d reset busErr", i), 64'(err[i]), 64'd0);
            check($sformatf("dut%0d reset busRData", i), 64'(rdata[i]), 64'd0);
        end

        // Zero wait states: merge and extension.
        st(0, "SW 04",          3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 1'b0);
        ld(0, "LW 04 a",        3'b010, 32'h1000_0004, 1'b0, 32'hDEAD_BEEF);
        st(0, "SB 05",          3'b000, 32'h1000_0005, 32'h0000_0080, 1'b0);
        ld(0, "LW 04 b",        3'b010, 32'h1000_0004, 1'b0, 32'hDEAD_80EF);
        ld(0, "LB 05",          3'b000, 32'h1000_0005, 1'b0, 32'hFFFF_FF80);
        ld(0, "LBU 05",         3'b100, 32'h1000_0005, 1'b0, 32'h0000_0080);
        st(0, "SH 06",          3'b001, 32'h1000_0006, 32'h0000_9234, 1'b0);
        ld(0, "LH 06",          3'b001, 32'h1000_0006, 1'b0, 32'hFFFF_9234);
        ld(0, "LHU 06",         3'b101, 32'h1000_0006, 1'b0, 32'h0000_9234);
        ld(0, "LW 04 c",        3'b010, 32'h1000_0004, 1'b0, 32'h9234_80EF);

        // Errors leave RAM untouched.
        ld(0, "LW 02 misalign", 3'b010, 32'h1000_0002, 1'b1, 32'd0);
        st(0, "SW 00",          3'b010, 32'h1000_0000, 32'h1234_5678, 1'b0);
        st(0, "SH 03 misalign", 3'b001, 32'h1000_0003, 32'hFFFF_FFFF, 1'b1);
        st(0, "SW below base",  3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        ld(0, "LW 00 a",        3'b010, 32'h1000_0000, 1'b0, 32'h1234_5678);
        st(0, "store f3 011",   3'b011, 32'h1000_0000, 32'hFFFF_FFFF, 1'b1);
        ld(0, "LW 00 b",        3'b010, 32'h1000_0000, 1'b0, 32'h1234_5678);
        ld(0, "load f3 110",    3'b110, 32'h1000_0000, 1'b1, 32'd0);
        st(0, "SW 3FC top",     3'b010, 32'h1000_03FC, 32'hCAFE_F00D, 1'b0);
        ld(0, "LW 3FC top",     3'b010, 32'h1000_03FC, 1'b0, 32'hCAFE_F00D);
        ld(0, "LW 400 range",   3'b010, 32'h1000_0400, 1'b1, 32'd0);

        // busWe and busRe together: store wins.
        issue(0, "SW+RE 0C",    1'b1, 1'b1, 3'b010, 32'h1000_000C, 32'hA5A5_5A5A, 1'b0, 32'd0);
        ld(0, "LW 0C",          3'b010, 32'h1000_000C, 1'b0, 32'hA5A5_5A5A);

        // Three wait states.
        st(1, "W3 SW 08",       3'b010, 32'h1000_0008, 32'h2222_2222, 1'b0);
        ld(1, "W3 LW 08 a",     3'b010, 32'h1000_0008, 1'b0, 32'h2222_2222);

        // Store aborted by reset while waiting.
        we[1] = 1'b1; strb[1] = 3'b010; addr[1] = 32'h1000_0008; wdata[1] = 32'h1111_1111;
        @(posedge clk); #1;
        we[1] = 1'b0; addr[1] = 32'd0; wdata[1] = 32'd0; strb[1] = 3'd0;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        check("W3 abort busReady", 64'(rdy[1]), 64'd0);
        check("W3 abort busErr",   64'(err[1]), 64'd0);
        check("W3 abort busRData", 64'(rdata[1]), 64'd0);
        ld(1, "W3 LW 08 b",     3'b010, 32'h1000_0008, 1'b0, 32'h2222_2222);
        ld(1, "W3 LH misalign", 3'b001, 32'h1000_0009, 1'b1, 32'd0);

        repeat (6) @(posedge clk);
        #1;
        check("dut0 pending responses", 64'(q0.size()), 64'd0);
        check("dut3 pending responses", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
